// File: rtl/icb_arbiter_2m1s.sv
// Two-master to one-slave ICB arbiter: round-robin with grant lock, in-order response routing.
// Latency: zero cycles on both the command and response paths (combinational muxing).
// Backpressure: a stalled command locks the grant; full ID FIFO blocks commands; rsp_rdy follows the head master.

// Generic synchronous FIFO with registered occupancy; DEPTH must be a power of 2.
// Latency: one cycle from push to visibility at the head.
// Backpressure: push ignored when full, pop ignored when empty.
module fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop_vld,
    output logic [W-1:0]             head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_acc;
    logic          pop_acc;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign push_acc = push_vld & ~full;
    assign pop_acc  = pop_vld & ~empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of 2.
            if (push_acc) wr_ptr <= wr_ptr + AW'(1);
            if (pop_acc)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_acc, pop_acc})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_ptr] <= push_dat;
    end
endmodule

module icb_arbiter_2m1s #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int OUTS   = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_icb_cmd_vld,
    output logic                  m0_icb_cmd_rdy,
    input  logic [ADDR_W-1:0]     m0_icb_cmd_addr,
    input  logic                  m0_icb_cmd_read,
    input  logic [DATA_W-1:0]     m0_icb_cmd_wdata,
    input  logic [DATA_W/8-1:0]   m0_icb_cmd_wmask,
    output logic                  m0_icb_rsp_vld,
    input  logic                  m0_icb_rsp_rdy,
    output logic [DATA_W-1:0]     m0_icb_rsp_rdata,
    output logic                  m0_icb_rsp_err,

    input  logic                  m1_icb_cmd_vld,
    output logic                  m1_icb_cmd_rdy,
    input  logic [ADDR_W-1:0]     m1_icb_cmd_addr,
    input  logic                  m1_icb_cmd_read,
    input  logic [DATA_W-1:0]     m1_icb_cmd_wdata,
    input  logic [DATA_W/8-1:0]   m1_icb_cmd_wmask,
    output logic                  m1_icb_rsp_vld,
    input  logic                  m1_icb_rsp_rdy,
    output logic [DATA_W-1:0]     m1_icb_rsp_rdata,
    output logic                  m1_icb_rsp_err,

    output logic                  s_icb_cmd_vld,
    input  logic                  s_icb_cmd_rdy,
    output logic [ADDR_W-1:0]     s_icb_cmd_addr,
    output logic                  s_icb_cmd_read,
    output logic [DATA_W-1:0]     s_icb_cmd_wdata,
    output logic [DATA_W/8-1:0]   s_icb_cmd_wmask,
    input  logic                  s_icb_rsp_vld,
    output logic                  s_icb_rsp_rdy,
    input  logic [DATA_W-1:0]     s_icb_rsp_rdata,
    input  logic                  s_icb_rsp_err,

    output logic [$clog2(OUTS):0] outs_cnt,
    output logic                  unexp_rsp
);
    logic last_grant;
    logic lock;
    logic locked_id;
    logic sel;
    logic sel_vld;
    logic cmd_hs;
    logic rsp_hs;
    logic head_id;
    logic fifo_full;
    logic fifo_empty;

    always_comb begin
        sel = last_grant;
        if (lock)
            sel = locked_id;
        else if (m0_icb_cmd_vld && !m1_icb_cmd_vld)
            sel = 1'b0;
        else if (m1_icb_cmd_vld && !m0_icb_cmd_vld)
            sel = 1'b1;
        else if (m0_icb_cmd_vld && m1_icb_cmd_vld)
            sel = ~last_grant;
    end

    assign sel_vld         = sel ? m1_icb_cmd_vld : m0_icb_cmd_vld;
    assign s_icb_cmd_addr  = sel ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    assign s_icb_cmd_read  = sel ? m1_icb_cmd_read  : m0_icb_cmd_read;
    assign s_icb_cmd_wdata = sel ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    assign s_icb_cmd_wmask = sel ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;

    // A full ID FIFO blocks commands even when a pop happens in the same cycle.
    assign s_icb_cmd_vld  = rst & sel_vld & ~fifo_full;
    assign m0_icb_cmd_rdy = rst & ~sel & s_icb_cmd_rdy & ~fifo_full;
    assign m1_icb_cmd_rdy = rst &  sel & s_icb_cmd_rdy & ~fifo_full;
    assign cmd_hs         = s_icb_cmd_vld & s_icb_cmd_rdy;

    assign m0_icb_rsp_vld   = rst & ~fifo_empty & ~head_id & s_icb_rsp_vld;
    assign m1_icb_rsp_vld   = rst & ~fifo_empty &  head_id & s_icb_rsp_vld;
    assign s_icb_rsp_rdy    = rst & ~fifo_empty & (head_id ? m1_icb_rsp_rdy : m0_icb_rsp_rdy);
    assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
    assign m1_icb_rsp_rdata = s_icb_rsp_rdata;
    assign m0_icb_rsp_err   = s_icb_rsp_err;
    assign m1_icb_rsp_err   = s_icb_rsp_err;
    assign rsp_hs           = s_icb_rsp_vld & s_icb_rsp_rdy;

    fifo #(
        .W     (1),
        .DEPTH (OUTS)
    ) u_id_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (cmd_hs),
        .push_dat (sel),
        .pop_vld  (rsp_hs),
        .head_dat (head_id),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .cnt      (outs_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
            lock       <= 1'b0;
            locked_id  <= 1'b0;
            unexp_rsp  <= 1'b0;
        end else begin
            // Hold the grant on a stalled command so the payload stays stable.
            if (cmd_hs) begin
                last_grant <= sel;
                lock       <= 1'b0;
            end else if (s_icb_cmd_vld) begin
                lock      <= 1'b1;
                locked_id <= sel;
            end
            if (s_icb_rsp_vld && fifo_empty)
                unexp_rsp <= 1'b1;
        end
    end
endmodule

// File: doc/icb_arbiter_2m1s.md
Name: icb_arbiter_2m1s

Overview:
- Shares one ICB slave port (GPU/VGA register and framebuffer space at 0xa0000000/0xa1000000) between two ICB masters, m0 (CPU) and m1 (fill/blit engine).
- Round-robin command arbitration with grant locking while a command is stalled.
- An in-order ID FIFO routes responses back to the issuing master.
- Zero-latency combinational cmd/rsp paths; sits between the masters and the GPU bus decoder.

Parameters:
- ADDR_W, 64, ICB address width.
- DATA_W, 64, ICB data width; wmask width is DATA_W/8.
- OUTS, 4, maximum outstanding commands (ID FIFO depth, power of 2, at least 2).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- mN_icb_cmd_vld (N=0,1)  input  1  master command valid
- mN_icb_cmd_rdy  output  1  command accepted from master N
- mN_icb_cmd_addr  input  ADDR_W  command address
- mN_icb_cmd_read  input  1  1=read, 0=write
- mN_icb_cmd_wdata  input  DATA_W  write data
- mN_icb_cmd_wmask  input  DATA_W/8  byte write mask
- mN_icb_rsp_vld  output  1  response valid to master N
- mN_icb_rsp_rdy  input  1  master N ready for response
- mN_icb_rsp_rdata  output  DATA_W  read data (s_icb_rsp_rdata, fanned out)
- mN_icb_rsp_err  output  1  response error (s_icb_rsp_err, fanned out)
- s_icb_cmd_vld  output  1  command valid to slave
- s_icb_cmd_rdy  input  1  slave accepts command
- s_icb_cmd_addr/read/wdata/wmask  output  ADDR_W/1/DATA_W/DATA_W/8  muxed command payload
- s_icb_rsp_vld  input  1  slave response valid
- s_icb_rsp_rdy  output  1  response ready to slave
- s_icb_rsp_rdata  input  DATA_W  slave read data
- s_icb_rsp_err  input  1  slave error
- outs_cnt  output  $clog2(OUTS)+1  outstanding command count
- unexp_rsp  output  1  sticky: response arrived with FIFO empty

Behaviour:
- Reset (rst=0, async):
  - last_grant=1 (m0 wins first); lock=0; FIFO empty; outs_cnt=0; unexp_rsp=0.
  - While rst=0, force s_icb_cmd_vld, both mN_icb_cmd_rdy, both mN_icb_rsp_vld and s_icb_rsp_rdy to 0.
  - Reset mid-operation drops all outstanding IDs; later stray responses set unexp_rsp.
- Grant selection (combinational):
  - If lock=1: sel=locked_id.
  - Else if only one master is valid, sel=that master.
  - Else if both are valid, sel = ~last_grant.
  - Else sel=last_grant (payload don't-care).
- Command path:
  - s_icb_cmd_vld = m[sel]_vld & ~fifo_full.
  - s payload = m[sel] payload.
  - m[sel]_rdy = s_icb_cmd_rdy & ~fifo_full; the other master's rdy=0.
- Full FIFO blocks all commands, even if a pop occurs in the same cycle.
- Handshake (s_icb_cmd_vld & s_icb_cmd_rdy): push sel into FIFO; last_grant<=sel; lock<=0.
- Stall (s_icb_cmd_vld & ~s_icb_cmd_rdy): lock<=1, locked_id<=sel, so the payload cannot switch masters before acceptance.
- Response path:
  - head = FIFO head ID.
  - If FIFO non-empty: m[head]_rsp_vld = s_icb_rsp_vld; s_icb_rsp_rdy = m[head]_rsp_rdy; the other rsp_vld=0.
  - Pop on s_icb_rsp_vld & s_icb_rsp_rdy.
- If FIFO empty: s_icb_rsp_rdy=0, both rsp_vld=0; s_icb_rsp_vld=1 sets unexp_rsp (cleared only by reset).
- Simultaneous push and pop (not full): count unchanged, pointers both advance, wrap modulo OUTS.
- outs_cnt = registered FIFO occupancy, range 0..OUTS.
- Latency: 0 cycles on cmd and rsp; responses return strictly in issue order.

Test Plan:
- Single master: m0 writes addr 0xa1000000, wdata 0x00ff00ff_00ff00ff, wmask 0xff; slave rdy=1; slave responds next cycle with err=0. Required: s_icb_cmd_* equal m0 payload in the same cycle; outs_cnt goes 0->1->0; m0_icb_rsp_vld=1 for one cycle; m1_icb_rsp_vld stays 0.
- Contention: m0 and m1 hold vld=1 continuously for 6 cycles, slave rdy=1. Required: accept order m0,m1,m0,m1,m0,m1; slave responds in order; each response is routed to the matching master.
- Lock: m1 presents read 0xa0000104 with slave rdy=0 for 3 cycles; m0 raises vld in cycle 2. Required: s_icb_cmd_addr stays 0xa0000104 until accepted, then m0 is granted the next cycle.
- FIFO full: OUTS=4 writes from m0 with no responses. Required: outs_cnt=4, m0_icb_cmd_rdy=0, s_icb_cmd_vld=0; after one response, outs_cnt=3 and the 5th command issues the following cycle.
- Backpressure/error: slave rsp_vld=1 with err=1 while m1 (head) has rsp_rdy=0 for 2 cycles. Required: s_icb_rsp_rdy=0 and no pop; m1 receives err=1 when it raises rdy.
- Stray response and reset: s_icb_rsp_vld=1 with FIFO empty sets unexp_rsp=1; assert rst=0 with 2 outstanding. Required: outs_cnt=0 and unexp_rsp=0 immediately, and all vld/rdy outputs are 0.
